// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
// Instruction-memory responder at the far end of the PC fetch interface.
// A fetch is accepted in IDLE, then waits LATENCY cycles in WAIT (skipped
// for a bad address), and the word is returned with a one-cycle valid_o
// pulse in RESP. stall_o holds the PC from the acceptance cycle until RESP.
// A write port loads program words at any time, regardless of fetch state.
//
// Ports:
//   clk_i      rising-edge clock
//   start_i    synchronous active-low reset (0 = reset, 1 = run)
//   req_i      fetch request, addr_i valid when high
//   addr_i     byte address from the PC register
//   flush_i    abort an in-flight fetch / suppress acceptance
//   wr_en_i    program-load write enable
//   wr_addr_i  word index for write
//   wr_data_i  write data
//   inst_o     returned instruction word (registered)
//   valid_o    one-cycle pulse, inst_o/err_o meaningful
//   err_o      set with valid_o for a misaligned or out-of-range address
//   stall_o    hold request to the PC register (combinational)
module imem_fetch_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk_i,
  input  logic                 start_i,
  input  logic                 req_i,
  input  logic [31:0]          addr_i,
  input  logic                 flush_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [31:0]          wr_data_i,
  output logic [31:0]          inst_o,
  output logic                 valid_o,
  output logic                 err_o,
  output logic                 stall_o
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Misaligned byte address, or any address bit above the memory's word range.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_BITS + 2)) != 32'd0);
  endfunction

  logic [31:0]          mem_r [0:DEPTH-1];
  state_t               state_r;
  state_t               state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_s;
  logic [ADDR_BITS-1:0] idx_r;
  logic                 bad_r;
  logic [ADDR_BITS-1:0] rd_idx_s;
  logic                 rd_bad_s;
  logic                 accept_s;
  logic                 resp_s;
  logic                 stall_s;

  // Next-state, counter and stall decode; the read address source depends on
  // whether RESP is entered straight from IDLE (live addr_i) or from WAIT.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    stall_s  = 1'b0;
    rd_idx_s = idx_r;
    rd_bad_s = bad_r;
    case (state_r)
      ST_IDLE: begin
        rd_idx_s = addr_i[ADDR_BITS+1:2];
        rd_bad_s = addr_bad(addr_i);
        if (req_i && !flush_i) begin
          accept_s = 1'b1;
          stall_s  = 1'b1;
          cnt_s    = LAT_LOAD;
          if ((LATENCY > 0) && !rd_bad_s) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_RESP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush_i) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          stall_s = 1'b1;
          cnt_s   = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_WAIT;
          end
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // RESP is never followed by RESP, so entering it is simply "next is RESP".
  assign resp_s  = (state_s == ST_RESP);
  // The PC must never be held while the block is in reset.
  assign stall_o = stall_s & start_i;

  // State, latched request and registered response outputs.
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= {ADDR_BITS{1'b0}};
      bad_r   <= 1'b0;
      inst_o  <= 32'h0000_0000;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        idx_r <= rd_idx_s;
        bad_r <= rd_bad_s;
      end
      valid_o <= resp_s;
      if (resp_s) begin
        err_o  <= rd_bad_s;
        // Nonblocking read: a write on this same edge is not yet visible.
        inst_o <= rd_bad_s ? 32'h0000_0000 : mem_r[rd_idx_s];
      end else begin
        err_o  <= 1'b0;
      end
    end
  end

  // Program-load port; memory is deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_r[wr_addr_i] <= wr_data_i;
    end
  end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder at the far end of the PC fetch interface. It accepts the fetch address driven by the PC register and returns the instruction word after a configurable wait. While the fetch is in flight it drives the stall signal that the PC register consumes, so the PC holds until the word is delivered. It also provides a write port for loading the program before or during a run.

Parameters:
ADDR_BITS, 8, word-index width; memory depth = 2**ADDR_BITS 32-bit words.
LATENCY, 2, wait cycles between request acceptance and data return (0 allowed).

Ports:
clk_i  input  1  clock; all state changes on rising edge.
start_i  input  1  synchronous active-low reset (0 = reset, 1 = run).
req_i  input  1  fetch request; addr_i valid when high.
addr_i  input  32  byte address from PC register.
flush_i  input  1  abort in-flight fetch (branch/jump redirect).
wr_en_i  input  1  program-load write enable.
wr_addr_i  input  ADDR_BITS  word index for write.
wr_data_i  input  32  write data.
inst_o  output  32  returned instruction word, registered.
valid_o  output  1  one-cycle pulse; inst_o/err_o meaningful.
err_o  output  1  set with valid_o for a misaligned or out-of-range address.
stall_o  output  1  to PC stall input; 1 = hold PC.

Behaviour:
- Reset (start_i=0 at the edge): state=IDLE, counter=0, inst_o=0, valid_o=0, err_o=0. Memory contents are not cleared.
- stall_o is forced to 0 while start_i=0. Reset during WAIT aborts the fetch with no valid_o.
- States: IDLE, WAIT, RESP.
- IDLE: request accepted when req_i=1 and flush_i=0. Address latched. Counter loaded with LATENCY.
  - Next state is WAIT if LATENCY>0 and the address is good.
  - Otherwise next state is RESP.
- Bad address: addr_i[1:0]!=0, or addr_i[31:ADDR_BITS+2]!=0. A bad address skips WAIT regardless of LATENCY.
- WAIT: counter decrements each cycle. When counter==1 (after the decrement it is 0), next state is RESP.
- RESP transition edge:
  - Good address: inst_o = mem[latched addr[ADDR_BITS+1:2]], err_o=0.
  - Bad address: inst_o=32'h0 (NOP), err_o=1.
  - valid_o=1 for exactly the RESP cycle; then return to IDLE.
- stall_o, combinational:
  - 1 in IDLE when req_i=1, flush_i=0 and start_i=1.
  - 1 in every WAIT cycle.
  - 0 in RESP, so the PC advances on the edge ending RESP.
  - 0 otherwise.
- Latency: valid_o is high exactly LATENCY+1 cycles after the acceptance edge (bad address: 1 cycle). stall_o is high for LATENCY+1 consecutive cycles starting with the acceptance cycle.
- No request is accepted in WAIT or RESP; req_i is ignored there. Back-to-back fetches: RESP, then IDLE accepts the next request the following cycle.
- flush_i:
  - In WAIT: return to IDLE next edge, no valid_o, stall_o=0 in the flush cycle.
  - In IDLE: suppresses acceptance.
  - In RESP: the valid_o pulse still occurs (already registered).
- Write port:
  - mem[wr_addr_i] <= wr_data_i on any edge with wr_en_i=1, independent of state.
  - The read happens on the edge entering RESP. A write on that same edge to the same word returns the OLD data. An earlier write during WAIT returns the NEW data.
- The latched address is never modified by addr_i changes during WAIT.

Test Plan:
- LATENCY=2, mem[3]=32'h00A00093. Reset 2 cycles, then req_i=1, addr_i=0x0C → stall_o high for 3 cycles (acceptance + 2 WAIT); valid_o=1, inst_o=32'h00A00093, err_o=0, stall_o=0 in the 4th cycle.
- Misaligned addr_i=0x0E and out-of-range addr_i=0x400 (ADDR_BITS=8) → stall_o 1 cycle; next cycle valid_o=1, inst_o=0, err_o=1.
- flush_i=1 in the first WAIT cycle of a fetch to 0x10 → no valid_o, stall_o=0 that cycle. A new req to 0x14 the next cycle completes normally with mem[5].
- Write mem[4]=32'hDEADBEEF during WAIT of a fetch to 0x10 → inst_o=32'hDEADBEEF. Write mem[4]=32'h12345678 on the edge entering RESP → inst_o keeps the prior value.
- start_i=0 mid-WAIT → stall_o=0 immediately, valid_o never pulses, outputs 0. Fetch after start_i=1 works.
- LATENCY=0: continuous req_i with addr 0,4,8 → valid every other cycle; stall_o pattern 1,0,1,0,1,0; inst_o = mem[0], mem[1], mem[2].
